// File: rtl/p256_pkg.sv
// p256_pkg: shared constants for the P-256 operand RAM port.
//   WORD_W / NUM_WORDS / OP_W / ADDR_W : operand geometry (8 x 32 = 256 bits)
//   ST_IDLE / ST_LOAD / ST_STORE       : FSM state encoding
//   P256_P_WORDS                       : the P-256 prime, index 0 = least-significant word
package p256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int OP_W      = WORD_W * NUM_WORDS;
    localparam int ADDR_W    = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;

    localparam logic [31:0] P256_P_WORDS [0:7] = '{
        32'hffffffff, 32'hffffffff, 32'hffffffff, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000001, 32'hffffffff
    };

    function automatic logic [31:0] p256_p_word(input logic [2:0] idx);
        return P256_P_WORDS[idx];
    endfunction

endpackage

// File: rtl/p256_word_cmp.sv
// p256_word_cmp: word-serial ">= P-256 prime" comparator, fed LSW first.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the comparison (flag back to 1, i.e. "equal so far")
//   en         : word/idx are valid this cycle
//   word, idx  : operand word and its position
//   ge         : result including the word presented this cycle, so the
//                caller can register the final answer on the last-word edge
module p256_word_cmp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] word,
    input  logic [2:0]  idx,
    output logic        ge
);
    import p256_pkg::*;

    logic        flag_reg;
    logic        flag_next;
    logic [31:0] p_word;

    assign p_word = p256_p_word(idx);

    // Later (more significant) words override earlier ones unless equal,
    // which yields a full-width magnitude compare after the MSW.
    always_comb begin
        flag_next = flag_reg;
        if (en) begin
            if (word > p_word)
                flag_next = 1'b1;
            else if (word < p_word)
                flag_next = 1'b0;
        end
    end

    assign ge = flag_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flag_reg <= 1'b1;
        else if (clr)
            flag_reg <= 1'b1;
        else
            flag_reg <= flag_next;
    end

endmodule

// File: rtl/ram_operand_port.sv
// ram_operand_port: word-serial master between the P-256 datapath and an
// 8x32 operand RAM (synchronous write, 1-cycle registered read).
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, op   : request (op 0 = LOAD, 1 = STORE), sampled only while idle
//   operand_in  : STORE data, captured on the accepting edge
//   operand_out : LOAD result, fully valid when done pulses
//   busy, done  : operation in progress / one-cycle completion pulse
//   ge_p        : last LOAD result >= P-256 prime
//   ram_addr, ram_we, ram_wdata, ram_rdata : RAM port
// Build option: define P256_GE_P_CHECK_EN to build the ge_p comparator;
// otherwise ge_p is tied 0.
module ram_operand_port #(
    parameter int WORD_W    = p256_pkg::WORD_W,
    parameter int NUM_WORDS = p256_pkg::NUM_WORDS,
    parameter int ADDR_W    = p256_pkg::ADDR_W,
    localparam int OP_W     = WORD_W * NUM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [OP_W-1:0]   operand_in,
    output logic [OP_W-1:0]   operand_out,
    output logic              busy,
    output logic              done,
    output logic              ge_p,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata
);
    import p256_pkg::*;

    localparam logic [3:0]        CNT_END  = 4'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    logic [1:0]        state_reg;
    logic [3:0]        cnt_reg;
    logic [OP_W-1:0]   store_buf_reg;
    // Read pipeline: stage 0 = address issued, stage 1 = RAM data on ram_rdata.
    logic              rd_v0_reg, rd_v1_reg;
    logic [ADDR_W-1:0] rd_idx0_reg, rd_idx1_reg;
    logic [WORD_W-1:0] word_reg [NUM_WORDS];

    logic capture;
    logic load_last;
    logic load_accept;

    assign capture     = (state_reg == ST_LOAD) && rd_v1_reg;
    assign load_last   = capture && (rd_idx1_reg == LAST_IDX);
    assign load_accept = (state_reg == ST_IDLE) && start && !op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            store_buf_reg <= '0;
            rd_v0_reg     <= 1'b0;
            rd_v1_reg     <= 1'b0;
            rd_idx0_reg   <= '0;
            rd_idx1_reg   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= '0;
        end else begin
            done        <= 1'b0;
            rd_v0_reg   <= 1'b0;
            rd_v1_reg   <= rd_v0_reg;
            rd_idx1_reg <= rd_idx0_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cnt_reg  <= 4'd1;
                        ram_addr <= '0;
                        if (op) begin
                            state_reg     <= ST_STORE;
                            store_buf_reg <= operand_in;
                            ram_wdata     <= operand_in[WORD_W-1:0];
                            ram_we        <= 1'b1;
                        end else begin
                            state_reg   <= ST_LOAD;
                            rd_v0_reg   <= 1'b1;
                            rd_idx0_reg <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cnt_reg < CNT_END) begin
                        ram_addr    <= cnt_reg[ADDR_W-1:0];
                        rd_v0_reg   <= 1'b1;
                        rd_idx0_reg <= cnt_reg[ADDR_W-1:0];
                        cnt_reg     <= cnt_reg + 4'd1;
                    end
                    if (load_last) begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cnt_reg   <= 4'd0;
                    end
                end
                ST_STORE: begin
                    if (cnt_reg < CNT_END) begin
                        ram_addr  <= cnt_reg[ADDR_W-1:0];
                        ram_wdata <= store_buf_reg[cnt_reg[ADDR_W-1:0]*WORD_W +: WORD_W];
                        cnt_reg   <= cnt_reg + 4'd1;
                    end else begin
                        state_reg <= ST_IDLE;
                        ram_we    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cnt_reg   <= 4'd0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    ram_we    <= 1'b0;
                end
            endcase
        end
    end

    // One capture register per word; only LOAD ever writes them.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                word_reg[gi] <= '0;
            else if (capture && (rd_idx1_reg == ADDR_W'(gi)))
                word_reg[gi] <= ram_rdata;
        end
        assign operand_out[gi*WORD_W +: WORD_W] = word_reg[gi];
    end

`ifdef P256_GE_P_CHECK_EN
    logic cmp_ge;

    p256_word_cmp u_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_accept),
        .en    (capture),
        .word  (ram_rdata),
        .idx   (rd_idx1_reg),
        .ge    (cmp_ge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ge_p <= 1'b0;
        else if (load_last)
            ge_p <= cmp_ge;
    end
`else
    logic unused_cmp;
    assign unused_cmp = load_accept;
    assign ge_p       = 1'b0;
`endif

endmodule

// File: tb/tb_ram_operand_port.sv
module tb_ram_operand_port;

    localparam logic [255:0] GX = 256'h6b17d1f2_e12c4247_f8bce6e5_63a440f2_77037d81_2deb33a0_f4a13945_d898c296;
    localparam logic [255:0] SV = 256'h47a2dcf8_7221ed74_a10df3da_be87133f_f4091278_764d0426_e024c340_6a3ca057;
    localparam logic [255:0] P  = 256'hffffffff_00000001_00000000_00000000_00000000_ffffffff_ffffffff_ffffffff;
`ifdef P256_GE_P_CHECK_EN
    localparam bit GE_EN = 1'b1;
`else
    localparam bit GE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [255:0] operand_in = '0;
    logic [255:0] operand_out;
    logic         busy, done, ge_p;
    logic [2:0]   ram_addr;
    logic         ram_we;
    logic [31:0]  ram_wdata;
    logic [31:0]  ram_rdata;

    // Backdoor preload port for the RAM model.
    logic         bk_we = 1'b0;
    logic [2:0]   bk_addr = '0;
    logic [31:0]  bk_data = '0;
    logic [31:0]  mem [0:7];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_operand_port dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_in  (operand_in),
        .operand_out (operand_out),
        .busy        (busy),
        .done        (done),
        .ge_p        (ge_p),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always @(posedge clk) begin
        if (bk_we)
            mem[bk_addr] <= bk_data;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [255:0] v);
        for (int i = 0; i < 8; i++) begin
            bk_we   = 1'b1;
            bk_addr = i[2:0];
            bk_data = v[i*32 +: 32];
            tick();
        end
        bk_we = 1'b0;
    endtask

    function automatic logic [255:0] mem_val();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = mem[i];
        return r;
    endfunction

    function automatic logic exp_ge(input logic [255:0] v);
        return GE_EN ? (v >= P) : 1'b0;
    endfunction

    // Issue one operation; report the edge index of done (edge 0 = accept),
    // the number of ram_we cycles and how many of them had a wrong addr/data.
    task automatic do_op(input logic op_i, input logic [255:0] data,
                         output int done_edge, output int we_cnt, output int bad_we);
        start      = 1'b1;
        op         = op_i;
        operand_in = data;
        tick();
        start      = 1'b0;
        operand_in = ~data;
        done_edge  = -1;
        we_cnt     = 0;
        bad_we     = 0;
        check("busy_rise", busy, 1'b1);
        for (int e = 0; e <= 30; e++) begin
            if (e > 0) tick();
            if (ram_we) begin
                if (we_cnt > 7 || ram_addr !== we_cnt[2:0] || ram_wdata !== data[we_cnt*32 +: 32])
                    bad_we++;
                we_cnt++;
            end
            if (done) begin
                done_edge = e;
                break;
            end
        end
    endtask

    initial begin
        int de, wc, bw, dcnt, dedge, last, ok;
        logic [255:0] oldv, newv, pm1, pp1;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_we", ram_we, 1'b0);
        check("rst_addr", ram_addr, 3'd0);
        check("rst_wdata", ram_wdata, 32'd0);
        check("rst_operand", operand_out, 256'd0);
        check("rst_gep", ge_p, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: LOAD of Gx
        preset(GX);
        do_op(1'b0, 256'd0, de, wc, bw);
        $display("[TB] LOAD Gx done_edge=%0d operand=%0h ge_p=%0b", de, operand_out, ge_p);
        check("t1_done_edge", de, 9);
        check("t1_operand", operand_out, GX);
        check("t1_gep", ge_p, exp_ge(GX));
        check("t1_no_we", wc, 0);
        check("t1_busy_low", busy, 1'b0);

        // 2: STORE then LOAD back
        do_op(1'b1, SV, de, wc, bw);
        $display("[TB] STORE done_edge=%0d we_cycles=%0d bad=%0d", de, wc, bw);
        check("t2_done_edge", de, 8);
        check("t2_we_cycles", wc, 8);
        check("t2_we_content", bw, 0);
        check("t2_we_low", ram_we, 1'b0);
        check("t2_w0", mem[0], 32'h6a3ca057);
        check("t2_w7", mem[7], 32'h47a2dcf8);
        check("t2_mem", mem_val(), SV);
        do_op(1'b0, 256'd0, de, wc, bw);
        $display("[TB] LOAD back done_edge=%0d operand=%0h", de, operand_out);
        check("t2_load_back", operand_out, SV);
        check("t2_gep", ge_p, exp_ge(SV));

        // 3: ge_p around the prime
        pm1 = P - 256'd1;
        pp1 = P + 256'd1;
        preset(P);
        do_op(1'b0, 256'd0, de, wc, bw);
        $display("[TB] LOAD p ge_p=%0b", ge_p);
        check("t3_p_operand", operand_out, P);
        check("t3_p_gep", ge_p, exp_ge(P));
        preset(pm1);
        do_op(1'b0, 256'd0, de, wc, bw);
        $display("[TB] LOAD p-1 ge_p=%0b", ge_p);
        check("t3_pm1_gep", ge_p, exp_ge(pm1));
        preset(pp1);
        do_op(1'b0, 256'd0, de, wc, bw);
        $display("[TB] LOAD p+1 ge_p=%0b", ge_p);
        check("t3_pp1_gep", ge_p, exp_ge(pp1));

        // 4: start pulses during a LOAD are ignored
        preset(GX);
        start = 1'b1;
        op    = 1'b0;
        tick();
        dcnt  = 0;
        dedge = -1;
        for (int e = 1; e <= 15; e++) begin
            start = (e == 3 || e == 5);
            tick();
            if (done) begin
                dcnt++;
                dedge = e;
            end
        end
        start = 1'b0;
        $display("[TB] LOAD with extra starts dones=%0d at edge %0d", dcnt, dedge);
        check("t4_done_count", dcnt, 1);
        check("t4_done_edge", dedge, 9);
        check("t4_operand", operand_out, GX);
        check("t4_idle", busy, 1'b0);

        // 5: reset in the middle of a STORE; word 3 is committed at edge 4
        oldv = 256'h0bad0007_0bad0006_0bad0005_0bad0004_0bad0003_0bad0002_0bad0001_0bad0000;
        newv = SV;
        preset(oldv);
        start      = 1'b1;
        op         = 1'b1;
        operand_in = newv;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        rst_n = 1'b0;
        #1;
        $display("[TB] reset mid-STORE we=%0b busy=%0b", ram_we, busy);
        check("t5_we_async", ram_we, 1'b0);
        check("t5_busy_async", busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_mem", mem_val(), {oldv[255:128], newv[127:0]});
        check("t5_operand_cleared", operand_out, 256'd0);
        check("t5_idle_we", ram_we, 1'b0);

        // 6a: start held high, back-to-back LOADs
        preset(GX);
        start = 1'b1;
        op    = 1'b0;
        tick();
        dcnt = 0;
        last = 0;
        ok   = 1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (done) begin
                if (e - last != ((dcnt == 0) ? 9 : 10) || operand_out !== GX) ok = 0;
                $display("[TB] continuous LOAD done at edge %0d operand=%0h", e, operand_out);
                last = e;
                dcnt++;
            end
        end
        start = 1'b0;
        check("t6_load_dones", dcnt, 4);
        check("t6_load_spacing", ok, 1);
        for (int i = 0; i < 20 && busy; i++) tick();
        check("t6_load_idle", busy, 1'b0);

        // 6b: start held high, back-to-back STOREs
        preset(oldv);
        start      = 1'b1;
        op         = 1'b1;
        operand_in = SV;
        tick();
        dcnt = 0;
        last = 0;
        ok   = 1;
        wc   = ram_we ? 1 : 0;
        for (int e = 1; e <= 35; e++) begin
            tick();
            if (ram_we) wc++;
            if (done) begin
                if (e - last != ((dcnt == 0) ? 8 : 9)) ok = 0;
                $display("[TB] continuous STORE done at edge %0d", e);
                last = e;
                dcnt++;
            end
        end
        start = 1'b0;
        check("t6_store_dones", dcnt, 4);
        check("t6_store_spacing", ok, 1);
        check("t6_store_we_cycles", wc, 32);
        for (int i = 0; i < 20 && busy; i++) tick();
        check("t6_store_idle", busy, 1'b0);
        check("t6_store_mem", mem_val(), SV);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
